// File: rtl/cnt_shifter.sv
// cnt_shifter: sequential shifter. It loads a data word on start and then shifts
// it one bit per clock, for a clamped amount taken from the mod-5 counter.
// Optional build macro: CNT_SHIFTER_ROTATE_EN adds the rot input, which makes
// the shifts rotations instead of zero-filled shifts.
module cnt_shifter #(
    parameter int WIDTH   = 8,
    parameter int MAX_AMT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       amt,
    input  logic             dir,
`ifdef CNT_SHIFTER_ROTATE_EN
    input  logic             rot,
`endif
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             rot_q, rot_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2:0]       amt_cl;
    logic             rot_in;
    logic             fill;

    // Counter values above MAX_AMT collapse onto MAX_AMT.
    assign amt_cl = (amt > 3'(MAX_AMT)) ? 3'(MAX_AMT) : amt;

`ifdef CNT_SHIFTER_ROTATE_EN
    assign rot_in = rot;
`else
    assign rot_in = 1'b0;
`endif

    // The fill bit is the bit that leaves the word when rotating, and 0 otherwise.
    assign fill = rot_q & (dir_q ? q_q[0] : q_q[WIDTH-1]);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    q_d     = d_in;
                    dir_d   = dir;
                    rot_d   = rot_in;
                    rem_d   = amt_cl;
                    state_d = (amt_cl == 3'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                q_d   = dir_q ? {fill, q_q[WIDTH-1:1]} : {q_q[WIDTH-2:0], fill};
                rem_d = rem_q - 3'd1;
                if (rem_q == 3'd1) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_cnt_shifter.sv
// Self-checking bench for cnt_shifter: a vector table, randomized operations
// checked against an arithmetic model, and hand-written corner sequences.
module tb_cnt_shifter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] amt = '0;
    logic       dir = 1'b0;
    logic       rot_v = 1'b0;
    logic [7:0] d_in = '0;
    logic [7:0] q;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnt_shifter #(.WIDTH(8), .MAX_AMT(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .amt(amt), .dir(dir),
`ifdef CNT_SHIFTER_ROTATE_EN
        .rot(rot_v),
`endif
        .d_in(d_in), .q(q), .busy(busy), .done(done)
    );

    typedef struct {
        logic [7:0] d;
        logic [2:0] a;
        logic       dr;
        logic       rt;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the result after min(a,4) one-bit moves, with rotate or zero fill.
    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a,
                                         input logic dr, input logic rt);
        int n;
        logic [15:0] dd;
        n = (a > 3'd4) ? 4 : int'(a);
`ifndef CNT_SHIFTER_ROTATE_EN
        rt = 1'b0;
`endif
        dd = {d, d};
        if (n == 0) return d;
        if (rt) return dr ? 8'(dd >> n) : 8'((dd << n) >> 8);
        return dr ? (d >> n) : 8'(d << n);
    endfunction

    // One full operation from an IDLE state, checking the cycle-exact timing.
    task automatic run_op(input string nm, input logic [7:0] d, input logic [2:0] a,
                          input logic dr, input logic rt, input logic [7:0] exp);
        int n;
        n = (a > 3'd4) ? 4 : int'(a);
        @(negedge clk);
        d_in = d; amt = a; dir = dr; rot_v = rt; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; d_in = ~d; amt = 3'($urandom); dir = ~dr; rot_v = ~rt;
        if (n == 0) begin
            chk({nm, ".done0"}, done, 1);
            chk({nm, ".busy0"}, busy, 0);
            chk({nm, ".q0"}, q, exp);
        end else begin
            chk({nm, ".busy_k"}, busy, 1);
            chk({nm, ".done_k"}, done, 0);
            for (int i = 1; i <= n; i++) begin
                @(posedge clk); #1;
                if (i < n) begin
                    chk({nm, ".busy_mid"}, busy, 1);
                    chk({nm, ".done_mid"}, done, 0);
                end else begin
                    chk({nm, ".done"}, done, 1);
                    chk({nm, ".busy_end"}, busy, 0);
                    chk({nm, ".q"}, q, exp);
                end
            end
        end
        @(posedge clk); #1;
        chk({nm, ".done_pulse"}, done, 0);
        chk({nm, ".busy_idle"}, busy, 0);
        chk({nm, ".q_hold"}, q, exp);
    endtask

    initial begin
        vec_t tbl[6];
        logic [7:0] rd;
        logic [2:0] ra;
        logic       rdr, rrt;

        tbl[0] = '{8'hB3, 3'd3, 1'b0, 1'b0, 8'h98};
        tbl[1] = '{8'hB3, 3'd4, 1'b1, 1'b0, 8'h0B};
        tbl[2] = '{8'hA5, 3'd0, 1'b0, 1'b0, 8'hA5};
        tbl[3] = '{8'hFF, 3'd7, 1'b0, 1'b0, 8'hF0};
        tbl[4] = '{8'h81, 3'd5, 1'b1, 1'b0, 8'h08};
        tbl[5] = '{8'h01, 3'd1, 1'b0, 1'b0, 8'h02};

        // Reset, then idle cycles with outputs unchanged.
        #12;
        chk("rst.q", q, 0); chk("rst.busy", busy, 0); chk("rst.done", done, 0);
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle.q", q, 0); chk("idle.busy", busy, 0); chk("idle.done", done, 0);
        end

        for (int i = 0; i < 6; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].d, tbl[i].a, tbl[i].dr, tbl[i].rt, tbl[i].exp);

`ifdef CNT_SHIFTER_ROTATE_EN
        run_op("rotl", 8'hB3, 3'd3, 1'b0, 1'b1, 8'h9D);
        run_op("rotr", 8'hB3, 3'd2, 1'b1, 1'b1, 8'hEC);
        run_op("rot0", 8'hB3, 3'd3, 1'b0, 1'b0, 8'h98);
`endif

        // Randomized operations against the model.
        for (int i = 0; i < 40; i++) begin
            rd = 8'($urandom); ra = 3'($urandom); rdr = 1'($urandom); rrt = 1'($urandom);
            run_op($sformatf("rnd%0d", i), rd, ra, rdr, rrt, model(rd, ra, rdr, rrt));
        end

        // A start pulse during SHIFT is dropped, not queued.
        @(negedge clk); d_in = 8'hB3; amt = 3'd3; dir = 1'b0; rot_v = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); d_in = 8'hFF; amt = 3'd1; dir = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ign.done", done, 1); chk("ign.q", q, 8'h98);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ign.noqueue_busy", busy, 0); chk("ign.noqueue_q", q, 8'h98);

        // start held high: one IDLE cycle between back-to-back operations.
        @(negedge clk); d_in = 8'h01; amt = 3'd1; dir = 1'b0; start = 1'b1;
        @(posedge clk); #1; chk("b2b.busy_k", busy, 1);
        @(posedge clk); #1; chk("b2b.done", done, 1); chk("b2b.q", q, 8'h02);
        @(posedge clk); #1; chk("b2b.idle_busy", busy, 0); chk("b2b.idle_done", done, 0);
        @(posedge clk); #1; chk("b2b.reaccept", busy, 1); chk("b2b.reload", q, 8'h01);
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; chk("b2b.end_busy", busy, 0);

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk); d_in = 8'hFF; amt = 3'd4; dir = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        chk("mid.busy_pre", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid.q", q, 0); chk("mid.busy", busy, 0); chk("mid.done", done, 0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk("mid.after_busy", busy, 0); chk("mid.after_q", q, 0);
        run_op("post_rst", 8'hB3, 3'd3, 1'b0, 1'b0, 8'h98);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global guard so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected end before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cnt_shifter.md
Name: cnt_shifter

Overview:
- Sequential shifter that consumes the 3-bit value produced by the up/down modulo-5 counter (cnt, range 0..4) as a shift amount.
- On a start request it loads a data word, then shifts it one bit per clock for the requested number of cycles, and reports completion with a one-cycle done pulse.
- Sits directly downstream of the counter in the counter/shifter datapath.

Parameters:
- WIDTH, 8, data word width in bits.
- MAX_AMT, 4, largest shift amount honoured; larger amt values are clamped to this (matches the counter's top value).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous reset, active-low.
- start  input  1  request; sampled only in IDLE.
- amt  input  3  shift amount; driven from the counter's cnt output.
- dir  input  1  0 = shift left (toward MSB), 1 = shift right (toward LSB).
- d_in  input  WIDTH  data loaded on an accepted start.
- q  output  WIDTH  shift register contents.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous, active-low (reset_n).
- Reset (reset_n=0, any time including mid-operation) takes effect immediately and clears:
  - state to IDLE
  - q to 0, busy to 0, done to 0
  - internal remaining-count and latched dir to 0
- Release of reset is synchronous to the next clk edge.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - If start=1 at edge k: q<=d_in; dir is latched; rem<=min(amt, MAX_AMT).
  - If the clamped amount is 0, the next state is DONE; otherwise the next state is SHIFT.
  - If start=0: hold; q keeps its last value.
- SHIFT:
  - Each edge shifts q by one position in the latched direction, filling with 0; rem<=rem-1.
  - On the edge where rem==1, that shift is the last and the next state is DONE.
  - busy=1 throughout SHIFT.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next edge returns to IDLE unconditionally.
- Latency: start accepted at edge k, n = clamped amount.
  - Shifts occur on edges k+1..k+n.
  - q holds the final value after edge k+n.
  - done is high during the cycle following edge k+n; IDLE is re-entered at edge k+n+1.
  - For n=0: q=d_in and done is high in the cycle after edge k; busy never rises.
- While state is SHIFT or DONE:
  - start is ignored; no queuing.
  - Changes on amt, dir and d_in have no effect; all are latched at acceptance.
- start held high continuously: a new operation is accepted on the first edge in IDLE, i.e. back-to-back operations have one IDLE cycle between them.
- Clamping: amt values 5..7 are treated as MAX_AMT.
- WIDTH must be greater than MAX_AMT.

Optional Feature:
- Macro: CNT_SHIFTER_ROTATE_EN.
- When defined, an extra input port rot (1 bit) is present and is latched with dir at start.
  - rot=1: shifts are rotations; the bit shifted out re-enters the vacated end.
  - rot=0: logical shift with zero fill.
- When undefined, the rot port does not exist and all shifts are logical with zero fill.
- Timing is identical in both builds.

Test Plan:
- Reset then idle: reset_n=0 for 1 cycle with start=0 -> q=8'h00, busy=0, done=0; outputs stay unchanged for 5 idle cycles.
- Left shift: d_in=8'b1011_0011, amt=3, dir=0, start pulse at edge k -> busy=1 after edges k+1..k+2; q=8'b1001_1000 after edge k+3; done=1 for exactly one cycle after edge k+3.
- Right shift at maximum: d_in=8'b1011_0011, amt=4, dir=1 -> q=8'b0000_1011 after 4 shift edges; done is a single pulse.
- Zero amount and clamp:
  - amt=0, d_in=8'hA5 -> q=8'hA5, done one cycle after the start edge, busy never high.
  - amt=7, d_in=8'hFF, dir=0 -> treated as 4, q=8'hF0.
- Ignored start and mid-op reset:
  - A start pulse during SHIFT with different d_in has no effect; the first result completes.
  - Separately, driving reset_n=0 during SHIFT -> q=0, busy=0, done=0 immediately, without waiting for a clock edge.
- Rotate build (CNT_SHIFTER_ROTATE_EN): d_in=8'b1011_0011, amt=3, dir=0, rot=1 -> q=8'b1001_1101; with rot=0 the result matches the logical case, 8'b1001_1000.
